imem_dmem_port_arbiter: RTL

- Shares one single-ported unified memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline.
- Grants one requester at a time and holds the memory handshake until the access completes.
- Returns read data to the granted side.
- Drives stall outputs that the pipeline-freeze logic ORs with the load-use/branch hazard freezes. Also honours branch flushes of an in-flight fetch.

---
 rtl/imem_dmem_port_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/imem_dmem_port_arbiter.sv
// Arbitrates one single-ported unified memory between instruction fetch and the MEM stage.
// Optional macro FETCH_STARVE_GUARD_EN bounds how long data grants may keep fetch waiting.
module imem_dmem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_kill,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  output logic          if_stall,
  input  logic          dm_read,
  input  logic          dm_write,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_valid,
  output logic          dm_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  typedef enum logic [1:0] {IDLE, DATA, FETCH} state_t;

  state_t state, state_next;
  logic   kill_flag;
  logic   dm_req, f_req, starve;
  logic   grant_data, grant_fetch, done, fetch_killed;

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end

  // A requester is excluded in its own valid cycle so it cannot be re-granted for the same access.
  assign dm_req       = (dm_read | dm_write) & ~dm_valid;
  assign f_req        = if_req & ~if_valid & ~if_kill;
  assign done         = mem_req & mem_ready;
  assign fetch_killed = kill_flag | if_kill;
  assign if_stall     = if_req & ~if_valid;
  assign dm_stall     = (dm_read | dm_write) & ~dm_valid;

  assign grant_fetch  = (state == IDLE) & f_req & (~dm_req | starve);
  assign grant_data   = (state == IDLE) & dm_req & ~grant_fetch;

`ifdef FETCH_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve_cnt;

  assign starve = (starve_cnt >= CW'(STARVE_LIMIT)) & f_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (grant_fetch) begin
      starve_cnt <= '0;
    end else if (grant_data && if_req && starve_cnt < CW'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign starve = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_data)       state_next = DATA;
        else if (grant_fetch) state_next = FETCH;
      end
      DATA, FETCH: if (done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      if_valid  <= 1'b0;
      dm_rdata  <= '0;
      dm_valid  <= 1'b0;
      kill_flag <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      case (state)
        IDLE: begin
          kill_flag <= 1'b0;
          if (grant_data) begin
            mem_req   <= 1'b1;
            mem_we    <= dm_write;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
          end else if (grant_fetch) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
          end
        end
        DATA: begin
          if (done) begin
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            dm_valid <= 1'b1;
            if (!mem_we) dm_rdata <= mem_rdata;
          end
        end
        FETCH: begin
          if (done) begin
            mem_req   <= 1'b0;
            kill_flag <= 1'b0;
            if (!fetch_killed) begin
              if_rdata <= mem_rdata;
              if_valid <= 1'b1;
            end
          end else if (if_kill) begin
            kill_flag <= 1'b1;
          end
        end
        default: mem_req <= 1'b0;
      endcase
    end
  end

endmodule
